// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht
//   IF-stage branch predictor. A direct-mapped table of saturating counters
//   sits alongside a tagged branch target buffer. When GHR_W > 0 the table
//   index is gshare-style: the PC index field XOR the global history.
//
// Ports
//   clk, rst          rising-edge clock; asynchronous active-low reset
//   pred_pc_i         fetch PC to look up (combinational, zero latency)
//   pred_hit_o        BTB entry valid and tag matches
//   pred_taken_o      predict taken (hit and counter MSB set)
//   pred_target_o     predicted target, 0 on a miss
//   upd_valid_i       resolved branch reported this cycle
//   upd_pc_i          PC of the resolved branch
//   upd_taken_i       actual direction
//   upd_target_i      actual taken target
//   upd_mispred_i     EX saw a mispredict (sampled only with upd_valid_i)
//   ghr_o             global history register (held at 0 when GHR_W = 0)
//   mispred_cnt_o     saturating mispredict count
module branch_predictor_bht #(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 0,
  parameter int TAG_W   = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [PC_W-1:0]                       pred_pc_i,
  output logic                                  pred_hit_o,
  output logic                                  pred_taken_o,
  output logic [PC_W-1:0]                       pred_target_o,
  input  logic                                  upd_valid_i,
  input  logic [PC_W-1:0]                       upd_pc_i,
  input  logic                                  upd_taken_i,
  input  logic [PC_W-1:0]                       upd_target_i,
  input  logic                                  upd_mispred_i,
  output logic [((GHR_W > 0) ? GHR_W : 1)-1:0]  ghr_o,
  output logic [31:0]                           mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int GW    = (GHR_W > 0) ? GHR_W : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];

  logic [GW-1:0]    ghr_q;
  logic [GW-1:0]    ghr_next;
  logic [IDX_W-1:0] ghr_ext;
  logic [31:0]      mispred_q;

  logic [IDX_W-1:0] pred_idx;
  logic [TAG_W-1:0] pred_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [CNT_W-1:0] upd_cnt;

  // Only the index and tag fields of each PC matter; the rest is sunk here.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc_i, upd_pc_i};

  generate
    if (GHR_W > 1) begin : g_ghr_multi
      assign ghr_ext  = IDX_W'(ghr_q);
      assign ghr_next = {ghr_q[GHR_W-2:0], upd_taken_i};
    end else if (GHR_W == 1) begin : g_ghr_one
      assign ghr_ext  = IDX_W'(ghr_q);
      assign ghr_next = upd_taken_i;
    end else begin : g_ghr_none
      // Pure bimodal: history never shifts and never reaches the index.
      assign ghr_ext  = '0;
      assign ghr_next = '0;
    end
  endgenerate

  assign pred_idx = pred_pc_i[IDX_W+1:2] ^ ghr_ext;
  assign pred_tag = pred_pc_i[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx  = upd_pc_i[IDX_W+1:2] ^ ghr_ext;
  assign upd_tag  = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is not
  // visible until the following cycle.
  assign pred_hit_o    = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
  assign pred_taken_o  = pred_hit_o && cnt_q[pred_idx][CNT_W-1];
  assign pred_target_o = pred_hit_o ? target_q[pred_idx] : '0;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_cnt = cnt_q[upd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
      ghr_q     <= '0;
      mispred_q <= '0;
    end else if (upd_valid_i) begin
      ghr_q <= ghr_next;
      if (upd_mispred_i && (mispred_q != 32'hFFFF_FFFF)) begin
        mispred_q <= mispred_q + 32'd1;
      end
      if (upd_hit) begin
        if (upd_taken_i) begin
          if (upd_cnt != CNT_MAX) cnt_q[upd_idx] <= upd_cnt + CNT_W'(1);
          target_q[upd_idx] <= upd_target_i;
        end else if (upd_cnt != '0) begin
          cnt_q[upd_idx] <= upd_cnt - CNT_W'(1);
        end
      end else if (upd_taken_i) begin
        // Allocate on a taken miss, evicting whatever shared the index.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target_i;
        cnt_q[upd_idx]    <= CNT_WT;
      end
    end
  end

  assign ghr_o         = ghr_q;
  assign mispred_cnt_o = mispred_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispred = 1'b0;

  // bimodal instance (defaults)
  logic        hit_b, taken_b;
  logic [31:0] target_b, cnt_b;
  logic [0:0]  ghr_b;

  // gshare instance (GHR_W = 4)
  logic        hit_g, taken_g;
  logic [31:0] target_g, cnt_g;
  logic [3:0]  ghr_g;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor_bht u_bim (
    .clk(clk), .rst(rst), .pred_pc_i(pred_pc),
    .pred_hit_o(hit_b), .pred_taken_o(taken_b), .pred_target_o(target_b),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_mispred_i(upd_mispred),
    .ghr_o(ghr_b), .mispred_cnt_o(cnt_b)
  );

  branch_predictor_bht #(.GHR_W(4)) u_gsh (
    .clk(clk), .rst(rst), .pred_pc_i(pred_pc),
    .pred_hit_o(hit_g), .pred_taken_o(taken_g), .pred_target_o(target_g),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_mispred_i(upd_mispred),
    .ghr_o(ghr_g), .mispred_cnt_o(cnt_g)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic mp);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tg; upd_mispred = mp;
    @(posedge clk);
    #1;
    upd_valid = 1'b0; upd_mispred = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    @(negedge clk);
    pred_pc = pc;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    // 1: reset state
    pred_pc = 32'h100;
    #3;
    chk("rst_hit_during", hit_b, 0);
    chk("rst_taken_during", taken_b, 0);
    chk("rst_target_during", target_b, 0);
    chk("rst_cnt_during", cnt_b, 0);
    @(negedge clk);
    rst = 1'b1;
    look(32'h100);
    chk("rst_hit_after", hit_b, 0);
    chk("rst_taken_after", taken_b, 0);
    chk("rst_target_after", target_b, 0);
    chk("rst_cnt_after", cnt_b, 0);

    // 2: allocate on taken miss -> weakly taken
    upd(32'h100, 1, 32'h200, 0);
    look(32'h100);
    chk("alloc_hit", hit_b, 1);
    chk("alloc_taken", taken_b, 1);
    chk("alloc_target", target_b, 32'h200);

    // 3: saturation; last taken rewrites target
    upd(32'h100, 1, 32'h200, 0);
    upd(32'h100, 1, 32'h200, 0);
    upd(32'h100, 1, 32'h240, 0);
    look(32'h100);
    chk("sat_hi_target", target_b, 32'h240);
    upd(32'h100, 0, 32'h999, 0);
    look(32'h100);
    chk("nt1_taken", taken_b, 1);
    upd(32'h100, 0, 32'h999, 0);
    look(32'h100);
    chk("nt2_taken", taken_b, 0);
    chk("nt2_hit", hit_b, 1);
    chk("nt2_target_kept", target_b, 32'h240);
    for (int i = 0; i < 3; i++) upd(32'h100, 0, 32'h0, 0);
    upd(32'h100, 1, 32'h240, 0);
    look(32'h100);
    chk("sat_lo_then_t1", taken_b, 0);
    upd(32'h100, 1, 32'h240, 0);
    look(32'h100);
    chk("sat_lo_then_t2", taken_b, 1);

    // 4: conflict at index 0, tag 2 evicts tag 1
    upd(32'h200, 1, 32'h300, 0);
    look(32'h100);
    chk("conflict_old_hit", hit_b, 0);
    chk("conflict_old_target", target_b, 0);
    look(32'h200);
    chk("conflict_new_hit", hit_b, 1);
    chk("conflict_new_taken", taken_b, 1);
    chk("conflict_new_target", target_b, 32'h300);
    chk("bimodal_ghr", ghr_b, 0);

    // 5: gshare history and indexing
    do_reset();
    upd(32'h4000, 1, 32'h1, 0);
    upd(32'h4000, 0, 32'h1, 0);
    upd(32'h4000, 1, 32'h1, 0);
    upd(32'h4000, 1, 32'h1, 0);
    chk("ghr_1011", ghr_g, 4'b1011);
    upd(32'h0, 1, 32'h77, 0);          // index 0 ^ 1011 = 11
    chk("ghr_0111", ghr_g, 4'b0111);
    look(32'h2C);                      // index 11 ^ 0111 = 12, empty
    chk("gsh_hist7_hit", hit_g, 0);
    for (int i = 0; i < 4; i++) upd(32'h1000, 0, 32'h0, 0);
    chk("ghr_cleared", ghr_g, 4'b0000);
    look(32'h2C);                      // index 11 ^ 0 = 11
    chk("gsh_idx11_hit", hit_g, 1);
    chk("gsh_idx11_taken", taken_g, 1);
    chk("gsh_idx11_target", target_g, 32'h77);

    // 6: same-cycle update, mispredict count, async reset
    do_reset();
    @(negedge clk);
    pred_pc = 32'h10;
    upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_target = 32'h55;
    #1;
    chk("same_cycle_hit", hit_b, 0);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    chk("next_cycle_hit", hit_b, 1);
    chk("next_cycle_target", target_b, 32'h55);
    for (int i = 0; i < 5; i++) upd(32'h3000, 0, 32'h0, 1);
    @(negedge clk);
    upd_valid = 1'b0; upd_mispred = 1'b1;
    @(posedge clk);
    #1;
    upd_mispred = 1'b0;
    chk("mispred_cnt5", cnt_b, 5);
    look(32'h10);
    chk("pre_rst_hit", hit_b, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_hit", hit_b, 0);
    chk("async_rst_taken", taken_b, 0);
    chk("async_rst_target", target_b, 0);
    chk("async_rst_cnt", cnt_b, 0);
    chk("async_rst_ghr", ghr_g, 0);
    #10;
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Parametrised branch predictor for the IF stage: a direct-mapped table of saturating counters (BHT) plus a tagged branch target buffer (BTB), with optional global history (gshare) indexing.
- IF presents the fetch PC each cycle and gets a same-cycle taken/target prediction.
- EX reports each resolved branch one cycle later or more. The report trains the table and the global history, and counts mispredictions.
- Generalises the earlier single-bit predict-flag stub: configurable depth, counter width, history length and tag width, and it outputs a target address.

Parameters:
- PC_W, 32, width of PC and target addresses.
- ENTRIES, 64, number of table entries; must be a power of two, at least 4.
- CNT_W, 2, saturating counter width, 1..4.
- GHR_W, 0, global history length in bits, 0..log2(ENTRIES); 0 selects pure bimodal indexing.
- TAG_W, 8, BTB tag width taken from PC bits above the index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- pred_pc_i  in  PC_W  fetch PC to predict.
- pred_hit_o  out  1  BTB entry valid and tag matches.
- pred_taken_o  out  1  predict taken.
- pred_target_o  out  PC_W  predicted target address.
- upd_valid_i  in  1  a resolved branch is reported this cycle.
- upd_pc_i  in  PC_W  PC of the resolved branch.
- upd_taken_i  in  1  actual branch direction.
- upd_target_i  in  PC_W  actual taken target.
- upd_mispred_i  in  1  EX detected a direction or target mispredict.
- ghr_o  out  max(GHR_W,1)  current global history register.
- mispred_cnt_o  out  32  saturating count of mispredicts.

Behaviour:
- IDX_W = log2(ENTRIES). The index field is pc[IDX_W+1:2] and the tag field is pc[IDX_W+TAG_W+1:IDX_W+2].
- Index = pc index field XOR the GHR zero-extended to IDX_W. When GHR_W = 0 the XOR term is 0.
- Reset (rst low, asynchronous):
  - all valid bits = 0;
  - every counter = 2^(CNT_W-1)-1, i.e. weakly not-taken;
  - tags and targets = 0;
  - GHR = 0;
  - mispred_cnt_o = 0.
- Outputs during and immediately after reset: pred_hit_o = 0, pred_taken_o = 0, pred_target_o = 0.
- Lookup is combinational from the registered state, with zero latency:
  - pred_hit_o = valid[idx] AND (tag[idx] == pred tag);
  - pred_taken_o = pred_hit_o AND counter[idx] MSB;
  - pred_target_o = target[idx] when pred_hit_o is 1, else 0.
- Update happens on the rising clk edge when upd_valid_i = 1. The index is computed with the GHR value before the edge.
  - Hit at the index, taken: counter increments, saturating at 2^CNT_W-1; target is rewritten with upd_target_i.
  - Hit at the index, not taken: counter decrements, saturating at 0; target is unchanged.
  - Miss, taken: allocate the entry (overwrite on a conflict). Set valid = 1, write the tag and target, and set the counter to 2^(CNT_W-1), i.e. weakly taken.
  - Miss, not taken: no table change.
  - GHR shifts left by one with upd_taken_i inserted at bit 0; the oldest bit is dropped. GHR_W = 0: ghr_o is held at 0.
  - upd_mispred_i = 1: mispred_cnt_o increments, saturating at 32'hFFFFFFFF. This input is only sampled when upd_valid_i = 1.
- upd_valid_i = 0: no state changes; the other upd_* inputs are ignored.
- A lookup and an update to the same index in the same cycle: the lookup returns the pre-update contents. The new value is visible from the next cycle.
- Resolved branches are expected in program order; there is no speculative history repair.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

Test Plan:
1. Reset, then pred_pc_i = 0x100 -> pred_hit_o = 0, pred_taken_o = 0, pred_target_o = 0, mispred_cnt_o = 0.
2. Defaults, GHR_W = 0. Update pc 0x100 taken to target 0x200, then look up 0x100 -> hit = 1, taken = 1 (counter = 2), target = 0x200.
3. Counter saturation, continuing from scenario 2:
   - 3 further taken updates -> counter stays at 3;
   - then 2 not-taken updates -> counter = 1, pred_taken_o = 0, hit = 1;
   - 3 more not-taken updates -> counter = 0 and stays there.
4. Conflict, ENTRIES = 64. Allocate pc 0x100, then update pc 0x100 + 0x100 (same index, different tag) taken -> the entry is overwritten, and a lookup of 0x100 gives hit = 0.
5. GHR_W = 4. Updates with directions 1,0,1,1 -> ghr_o = 4'b1011. Then a taken update at pc 0x0 writes index 11; lookup of pc 0x2C with ghr 0 hits.
6. Mispredict counting and same-cycle behaviour:
   - same-cycle lookup and update of an empty index -> hit = 0 that cycle, hit = 1 the next cycle;
   - 5 updates with upd_mispred_i = 1 and 1 with upd_valid_i = 0 -> mispred_cnt_o = 5;
   - assert rst mid-test -> all outputs return to their reset values immediately.
